// File: rtl/btn_debounce.sv
// Per-bit button conditioner: synchroniser, tick-based debounce filter and press/release pulses.
// Define BTN_DEBOUNCE_LONGPRESS_EN to add per-bit long-press detection on o_long.
module btn_debounce #(
    parameter int unsigned     NBTN       = 8,
    parameter int unsigned     NFF        = 2,
    parameter int unsigned     DB_TICKS   = 16,
    parameter logic [NBTN-1:0] INVERT     = '0,
    parameter int unsigned     LONG_TICKS = 1000
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_ce,
    input  logic [NBTN-1:0] i_btn,
    output logic [NBTN-1:0] o_btn,
    output logic [NBTN-1:0] o_press,
    output logic [NBTN-1:0] o_release,
    output logic [NBTN-1:0] o_long
);

    localparam int unsigned      CNT_W   = $clog2(DB_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_TICKS - 1);

    generate
        if (NBTN < 1 || NBTN > 32 || NFF < 2 || DB_TICKS < 2 || LONG_TICKS < 1) begin : g_param_check
            $error("btn_debounce: illegal parameter set");
        end
    endgenerate

    logic [NFF-1:0][NBTN-1:0] sync_q;
    logic [NBTN-1:0]          sync_btn;
    logic [CNT_W-1:0]         db_cnt_q [NBTN];
    logic [CNT_W-1:0]         db_cnt_d [NBTN];
    logic [NBTN-1:0]          toggle;
    logic [NBTN-1:0]          btn_q;
    logic [NBTN-1:0]          press_q;
    logic [NBTN-1:0]          release_q;

    // Raw pins are asynchronous; polarity is fixed up before the first stage.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NFF-2:0], i_btn ^ INVERT};
        end
    end

    assign sync_btn = sync_q[NFF-1];

    // A bit only flips after DB_TICKS consecutive ticks of disagreement; any agreement restarts the run.
    always_comb begin
        db_cnt_d = db_cnt_q;
        toggle   = '0;
        for (int k = 0; k < int'(NBTN); k++) begin
            if (sync_btn[k] == btn_q[k]) begin
                db_cnt_d[k] = '0;
            end else if (i_ce) begin
                if (db_cnt_q[k] == CNT_MAX) begin
                    db_cnt_d[k] = '0;
                    toggle[k]   = 1'b1;
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < int'(NBTN); k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(NBTN); k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
            end
        end
    end

    // Edge pulses are registered alongside the level so they line up with the new o_btn value.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            btn_q     <= btn_q ^ toggle;
            press_q   <= toggle & ~btn_q;
            release_q <= toggle & btn_q;
        end
    end

    assign o_btn     = btn_q;
    assign o_press   = press_q;
    assign o_release = release_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_FIRE = HOLD_W'(LONG_TICKS - 1);

    logic [HOLD_W-1:0] hold_q [NBTN];
    logic [HOLD_W-1:0] hold_d [NBTN];
    logic [NBTN-1:0]   long_d;
    logic [NBTN-1:0]   long_q;

    // Saturating at HOLD_MAX is what limits o_long to a single pulse per press.
    always_comb begin
        hold_d = hold_q;
        long_d = '0;
        for (int k = 0; k < int'(NBTN); k++) begin
            if (!btn_q[k]) begin
                hold_d[k] = '0;
            end else if (i_ce && (hold_q[k] != HOLD_MAX)) begin
                hold_d[k] = hold_q[k] + 1'b1;
                long_d[k] = (hold_q[k] == HOLD_FIRE);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int k = 0; k < int'(NBTN); k++) begin
                hold_q[k] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int k = 0; k < int'(NBTN); k++) begin
                hold_q[k] <= hold_d[k];
            end
            long_q <= long_d;
        end
    end

    assign o_long = long_q;
`else
    assign o_long = '0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a tick-counting behavioural model.
module tb_btn_debounce;

    localparam int         NB    = 4;
    localparam int         NFF_T = 2;
    localparam int         DBT   = 4;
    localparam int         LT    = 8;
    localparam logic [3:0] INV   = 4'b1000;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam logic [3:0] LONG_EXP = 4'hF;
`else
    localparam logic [3:0] LONG_EXP = 4'h0;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_ce;
    logic [NB-1:0] i_btn;
    logic [NB-1:0] o_btn;
    logic [NB-1:0] o_press;
    logic [NB-1:0] o_release;
    logic [NB-1:0] o_long;

    int checks = 0;
    int errors = 0;

    btn_debounce #(
        .NBTN      (NB),
        .NFF       (NFF_T),
        .DB_TICKS  (DBT),
        .INVERT    (INV),
        .LONG_TICKS(LT)
    ) dut (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .i_ce     (i_ce),
        .i_btn    (i_btn),
        .o_btn    (o_btn),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pins, input logic ce);
        i_btn = pins;
        i_ce  = ce;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Behavioural model: pin history queue gives the synchronised view; per-bit tick counts of the
    // current disagreement run and of the current debounced hold decide the outputs.
    logic [3:0] hist [$];
    int         run  [NB];
    int         held [NB];
    logic [3:0] m_btn, m_press, m_release, m_long;
    logic [3:0] sync_pre, btn_pre;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hist.delete();
            for (int i = 0; i < NFF_T; i++) hist.push_back(4'h0);
            for (int k = 0; k < NB; k++) begin
                run[k]  = 0;
                held[k] = 0;
            end
            m_btn = 0; m_press = 0; m_release = 0; m_long = 0;
        end else begin
            sync_pre  = hist[NFF_T-1];
            btn_pre   = m_btn;
            m_press   = 0;
            m_release = 0;
            m_long    = 0;
            for (int k = 0; k < NB; k++) begin
                if (!btn_pre[k]) held[k] = 0;
                else if (i_ce) begin
                    held[k]++;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
                    if (held[k] == LT) m_long[k] = 1'b1;
`endif
                end
                if (sync_pre[k] == btn_pre[k]) run[k] = 0;
                else if (i_ce) begin
                    run[k]++;
                    if (run[k] == DBT) begin
                        run[k]   = 0;
                        m_btn[k] = ~btn_pre[k];
                        if (btn_pre[k]) m_release[k] = 1'b1;
                        else            m_press[k]   = 1'b1;
                    end
                end
            end
            hist.push_front(i_btn ^ INV);
            void'(hist.pop_back());
        end
    end

    always @(negedge i_clk) begin
        checkOutput("model o_btn", o_btn, m_btn);
        checkOutput("model o_press", o_press, m_press);
        checkOutput("model o_release", o_release, m_release);
        checkOutput("model o_long", o_long, m_long);
    end

    int         long_cnt;
    int         pat [8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    logic [3:0] flip;
    logic       ce_r;

    initial begin
        i_reset_n = 1'b0;
        applyStimulus(4'hF, 1'b1);

        // Reset held with pins active: everything stays low.
        repeat (10) begin
            tick();
            checkOutput("reset o_btn", o_btn, 4'h0);
            checkOutput("reset o_press", o_press, 4'h0);
        end
        i_reset_n = 1'b1;
        repeat (5) begin
            tick();
            checkOutput("post-reset o_btn early", o_btn, 4'h0);
        end
        tick();
        checkOutput("post-reset o_btn", o_btn, 4'h7);
        checkOutput("post-reset o_press", o_press, 4'h7);
        tick();
        checkOutput("post-reset press width", o_press, 4'h0);

        // All pins low: bits 0-2 release, inverted bit 3 presses.
        applyStimulus(4'h0, 1'b1);
        repeat (5) begin
            tick();
            checkOutput("release o_btn early", o_btn, 4'h7);
        end
        tick();
        checkOutput("release o_btn", o_btn, 4'h8);
        checkOutput("release o_press", o_press, 4'h8);
        checkOutput("release o_release", o_release, 4'h7);

        // Three-clock glitch on bit 1 must be rejected.
        applyStimulus(4'h2, 1'b1);
        repeat (3) tick();
        applyStimulus(4'h0, 1'b1);
        repeat (7) tick();
        checkOutput("glitch o_btn", o_btn, 4'h8);

        // Bouncy press 1,1,1,0,1,1,1,1 then held.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(pat[i] != 0 ? 4'h2 : 4'h0, 1'b1);
            tick();
        end
        tick();
        checkOutput("bounce o_btn early", o_btn, 4'h8);
        tick();
        checkOutput("bounce o_btn", o_btn, 4'hA);
        checkOutput("bounce o_press", o_press, 4'h2);

        // Slow tick: one i_ce in five while bit 2 is pressed.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'h6, (i % 5) == 0);
            tick();
            if (i == 9) checkOutput("slow tick o_btn early", o_btn, 4'hA);
        end
        checkOutput("slow tick o_btn", o_btn, 4'hE);
        applyStimulus(4'h6, 1'b1);
        repeat (4) tick();

        // Reset during the second counting clock of a bit 0 press.
        applyStimulus(4'h7, 1'b1);
        repeat (4) tick();
        i_reset_n = 1'b0;
        #1;
        checkOutput("mid-count reset o_btn", o_btn, 4'h0);
        repeat (2) tick();
        i_reset_n = 1'b1;
        repeat (5) begin
            tick();
            checkOutput("restart o_btn early", o_btn, 4'h0);
        end
        tick();
        checkOutput("restart o_btn", o_btn, 4'hF);
        checkOutput("restart o_press", o_press, 4'hF);

        // Long press fires exactly LT ticks after the debounced rise, once only.
        repeat (7) begin
            tick();
            checkOutput("long early", o_long, 4'h0);
        end
        tick();
        checkOutput("long pulse", o_long, LONG_EXP);
        long_cnt = 0;
        repeat (50) begin
            tick();
            if (o_long[0]) long_cnt++;
        end
        checkOutput("long repeat count", 4'(long_cnt), 4'h0);
        applyStimulus(4'h0, 1'b1);
        repeat (10) tick();
        applyStimulus(4'h7, 1'b1);
        long_cnt = 0;
        repeat (20) begin
            tick();
            if (o_long[0]) long_cnt++;
        end
        checkOutput("long re-arm count", 4'(long_cnt), {3'b000, LONG_EXP[0]});

        // Randomized pins, tick strobe and occasional resets against the model.
        for (int c = 0; c < 3000; c++) begin
            flip = 4'h0;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 9) == 0) flip[b] = 1'b1;
            end
            ce_r = (c < 1500) ? 1'b1 : ($urandom_range(0, 3) != 0);
            applyStimulus(i_btn ^ flip, ce_r);
            if ($urandom_range(0, 599) == 0) begin
                i_reset_n = 1'b0;
                tick();
                tick();
                i_reset_n = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Per-bit button conditioner directly upstream of the spio peripheral: raw board button pins in, clean debounced levels out to spio's i_btn.
- Synchronises each pin, filters bounce with a tick-based stability counter, and emits one-cycle press/release pulses for interrupt or event logic.
- Pure datapath. No bus interface.

Parameters:
- NBTN, 8, number of button bits (1..32)
- NFF, 2, synchroniser depth in flip-flops (>=2)
- DB_TICKS, 16, consecutive i_ce ticks an input must differ from o_btn before o_btn follows it (>=2)
- INVERT, 0, NBTN-bit mask; a set bit inverts that raw input (active-low pins)
- LONG_TICKS, 1000, ticks of continuous debounced press before o_long fires (used only with the optional feature)

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous active-low reset
- i_ce  in  1  sample tick strobe (e.g. 1 kHz); tie high to count clocks
- i_btn  in  NBTN  raw asynchronous button pins
- o_btn  out  NBTN  debounced level; feeds spio i_btn
- o_press  out  NBTN  one-cycle pulse per bit on debounced 0->1
- o_release  out  NBTN  one-cycle pulse per bit on debounced 1->0
- o_long  out  NBTN  one-cycle long-press pulse per bit

Behaviour:
- Interface: one clock (i_clk); reset is asynchronous and active-low (i_reset_n).
- Reset (async assert, release synchronous to i_clk): synchroniser regs, all counters, o_btn, o_press, o_release and o_long go to 0.
- Synchroniser: (i_btn ^ INVERT) passes through an NFF-stage shift register every clock, independent of i_ce. sync[k] is the last stage.
- Per-bit debounce counter, width clog2(DB_TICKS):
  - If sync[k] == o_btn[k]: counter cleared every clock, whether or not i_ce is high.
  - If sync[k] != o_btn[k] and i_ce, and counter < DB_TICKS-1: counter increments.
  - If sync[k] != o_btn[k] and i_ce, and counter == DB_TICKS-1: o_btn[k] toggles and the counter clears.
  - If sync[k] != o_btn[k] and !i_ce: counter holds.
- Latency with i_ce constantly high: o_btn changes exactly NFF+DB_TICKS clock edges after the first edge that samples the new pin value.
- Any mismatch run shorter than DB_TICKS ticks is ignored. A return to a match restarts the count from 0.
- o_press[k] is high during the single cycle following the 0->1 toggle of o_btn[k]. o_release[k] is the same for 1->0. Both are registered and never high simultaneously for one bit.
- Bits are fully independent. Simultaneous toggles on several bits produce simultaneous pulses.
- Asserting i_reset_n low mid-count discards the partial count. Any pulse in flight is cleared immediately.
- No wrap-around: the counter never exceeds DB_TICKS-1.

Optional Feature:
- Macro: BTN_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - Per-bit hold counter, width clog2(LONG_TICKS+1).
  - Clears while o_btn[k]==0. Increments on i_ce while o_btn[k]==1. Saturates at LONG_TICKS.
  - o_long[k] pulses for one cycle on the clock edge where the counter reaches LONG_TICKS. At most one pulse per press.
  - Release followed by a new press re-arms it.
- Undefined: hold counters are not generated, and o_long is constant 0.

Test Plan:
- All tests use NBTN=4, NFF=2, DB_TICKS=4, INVERT=0 and i_ce=1 unless stated.
- Reset: drive i_btn=4'hF with i_reset_n=0 for 10 clocks -> o_btn=0, o_press=0, o_release=0, o_long=0 throughout. Release reset -> o_btn=4'hF 6 clocks later, with o_press=4'hF for exactly 1 cycle.
- Clean press/release on bit0: i_btn[0] 0->1 sampled at edge 1 -> o_btn[0]=1 at edge 6 and o_press[0]=1 for one cycle. Drop to 0 -> o_btn[0]=0 six edges later with one o_release[0] pulse.
- Bounce/glitch: i_btn[1] pulse of 3 clocks -> o_btn[1] stays 0, no pulses. Pattern 1,1,1,0,1,1,1,1 -> o_btn[1] rises only after the final 4-tick stable run, with exactly one o_press[1].
- Slow tick: i_ce high one clock in 5, bit2 pressed and held -> o_btn[2] rises on the 4th i_ce after the sync output changes. The counter holds between ticks.
- INVERT=4'b1000: i_btn[3] held 0 -> o_btn[3]=1 after 6 clocks. Async reset pulsed at the 2nd counting clock of a later bit0 press -> counts restart and o_btn[0] rises 6 clocks after release.
- With BTN_DEBOUNCE_LONGPRESS_EN and LONG_TICKS=8: hold bit0 -> o_long[0] pulses exactly 8 ticks after o_btn[0] rises, once only over 50 further clocks. Release then re-press -> second pulse. Without the macro -> o_long stays 0.
